log2_seq: RTL and testbench
===========================

# log2_seq

Parametrised, handshaked floor-log2 unit. Accepts an arbitrary WIDTH-bit unsigned word (not restricted to one-hot) and returns the index of its most significant set bit, plus zero and power-of-two flags. The word is scanned MSB-first, CHUNK bits per cycle, with early exit, so latency depends on the input. It sits between register-level producers and consumers that need exponent/normalisation information, using valid/ready on both sides.

## Interface

Parameters:
- WIDTH, 32: input word width; must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 8: bits examined per scan cycle; must be ≥ 1.
- DEG_W, $clog2(WIDTH) (localparam): degree width.
- NCHUNK, WIDTH/CHUNK (localparam): number of scan chunks.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_num is valid.
- in_ready  out  1  block can accept; equals (state == IDLE).
- in_num  in  WIDTH  operand.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_degree  out  DEG_W  floor(log2(in_num)); 0 when the operand is zero.
- out_zero  out  1  operand was 0.
- out_pow2  out  1  operand had exactly one bit set.

## Operation

- States: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE: in_ready = 1. When in_valid && in_ready at an edge:
  - latch in_num into num_q;
  - compute pow2_q = (num_q != 0) && ((num_q & (num_q − 1)) == 0) from in_num;
  - set idx = NCHUNK−1;
  - go to SCAN.
- SCAN: examine chunk num_q[idx*CHUNK +: CHUNK].
  - Chunk nonzero: out_degree ← idx*CHUNK + (MSB position inside the chunk); out_zero ← 0; out_pow2 ← pow2_q; go to DONE.
  - Chunk zero and idx == 0: out_degree ← 0; out_zero ← 1; out_pow2 ← 0; go to DONE.
  - Otherwise: idx ← idx−1; stay in SCAN.
- DONE: out_valid = 1. Result outputs are held stable until out_valid && out_ready, then the block returns to IDLE.
- in_valid is ignored outside IDLE. There is no overlap between operations.
- out_degree, out_zero and out_pow2 are registers. They keep the last result after DONE is left and change only on a SCAN→DONE transition.
- Arithmetic: idx is $clog2(NCHUNK) bits wide, or 1 bit when NCHUNK = 1. Degree is computed without truncation because idx*CHUNK + pos ≤ WIDTH−1 fits in DEG_W.
- CHUNK = WIDTH: single-cycle scan, fixed latency 1.
- CHUNK = 1: bit-serial scan, latency up to WIDTH.

## Timing

- Reset values: in_ready = 1, out_valid = 0, out_degree = 0, out_zero = 0, out_pow2 = 0. Internal state is IDLE, num_q = 0, idx = 0.
- No transfer is possible while rst_n is low.
- Latency: the accept edge is E0. out_valid rises after edge E(NCHUNK − k), where k is the index of the highest nonzero chunk (k = 0 for a zero operand).
  - Minimum latency is 1 edge (MSB in the top chunk).
  - Maximum latency is NCHUNK edges (operand in chunk 0, or zero).
- Output handshake at edge En: IDLE in cycle n+1. The earliest next accept is edge En+1.
- Peak throughput is one result per (latency + 2) cycles when out_ready is held high.
- Asynchronous reset asserted in SCAN or DONE:
  - immediate return to IDLE with all outputs at their reset values;
  - the in-flight operand is discarded and no result is produced.

## Test plan

Conditions: WIDTH=32, CHUNK=8, out_ready=1 unless stated.

- Input 0x8000_0000 accepted at E0 -> out_valid after E1; degree=31, pow2=1, zero=0. in_ready low from E0 until the cycle after the output handshake.
- Input 0x0001_2345 -> out_valid after E2; degree=16, pow2=0, zero=0. Input 0x0000_0001 -> out_valid after E4; degree=0, pow2=1.
- Input 0x0000_0000 -> out_valid after E4; degree=0, zero=1, pow2=0. Next input 0x40 -> degree=6, zero=0, pow2=1.
- Backpressure: out_ready held low 5 cycles in DONE with in_valid=1 and in_num changing each cycle -> all outputs stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE the next cycle, then the new operand is accepted.
- rst_n pulsed low while in SCAN on operand 0x0000_00FF -> out_valid stays 0, outputs go to 0, in_ready=1 immediately. No stale result appears after reset is released.
- Parameter sweep: (WIDTH, CHUNK) = (8,8), (8,1), (64,16), all 2^WIDTH or random operands -> degree matches the reference floor-log2 model, and latency matches NCHUNK − k on every operand.

Source files
------------

// File: rtl/log2_seq.sv
// log2_seq: handshaked floor-log2 unit with a chunked MSB-first scan.
// Returns MSB index, zero flag and power-of-two flag per operand.
module log2_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int DEG_W = $clog2(WIDTH),
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEG_W-1:0] out_degree,
  output logic             out_zero,
  output logic             out_pow2
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] num_q;
  logic [IW-1:0]    idx;
  logic             pow2_q;
  logic [CHUNK-1:0] chunk;
  logic             hit;
  logic             last;
  logic             in_pow2;

  function automatic logic [PW-1:0] msb_pos(
    input logic [CHUNK-1:0] c
  );
    msb_pos = '0;
    for (int i = 0; i < CHUNK; i++)
      if (c[i]) msb_pos = PW'(i);
  endfunction

  assign chunk = num_q[int'(idx)*CHUNK +: CHUNK];
  assign hit   = |chunk;
  assign last  = (idx == '0);

  // pow2 is judged on the whole word up front
  assign in_pow2 = (in_num != '0) &&
    ((in_num & (in_num - WIDTH'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (in_valid) state_d = SCAN;
      SCAN: if (hit || last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q      <= '0;
      idx        <= '0;
      pow2_q     <= 1'b0;
      out_degree <= '0;
      out_zero   <= 1'b0;
      out_pow2   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE) && in_valid: begin
          num_q  <= in_num;
          pow2_q <= in_pow2;
          idx    <= IW'(NCHUNK - 1);
        end
        (state == SCAN) && hit: begin
          out_degree <= DEG_W'(int'(idx) * CHUNK
                        + int'(msb_pos(chunk)));
          out_zero   <= 1'b0;
          out_pow2   <= pow2_q;
        end
        (state == SCAN) && !hit && last: begin
          out_degree <= '0;
          out_zero   <= 1'b1;
          out_pow2   <= 1'b0;
        end
        (state == SCAN) && !hit && !last: begin
          idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_seq.sv
// tb_log2_seq: vector table, backpressure/reset sequences and
// randomized checks of log2_seq across four parameter sets.
module tb_log2_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic        ordy;
  logic [63:0] num;
  int          sel;

  logic [3:0]  iv, ir, ov, z, p;
  logic [4:0]  d0;
  logic [2:0]  d1, d2;
  logic [5:0]  d3;

  logic        cur_ir, cur_ov, cur_z, cur_p;
  int          cur_deg;

  int errors = 0;
  int checks = 0;

  int WS[4] = '{32, 8, 8, 64};
  int CS[4] = '{8, 8, 1, 16};

  always #5 clk = ~clk;

  always_comb begin
    iv = '0;
    iv[sel] = vld;
  end

  always_comb begin
    cur_ir = ir[sel];
    cur_ov = ov[sel];
    cur_z  = z[sel];
    cur_p  = p[sel];
    case (sel)
      0:       cur_deg = int'(d0);
      1:       cur_deg = int'(d1);
      2:       cur_deg = int'(d2);
      default: cur_deg = int'(d3);
    endcase
  end

  log2_seq #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_num(num[31:0]), .out_valid(ov[0]), .out_ready(ordy),
    .out_degree(d0), .out_zero(z[0]), .out_pow2(p[0]));

  log2_seq #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_num(num[7:0]), .out_valid(ov[1]), .out_ready(ordy),
    .out_degree(d1), .out_zero(z[1]), .out_pow2(p[1]));

  log2_seq #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_num(num[7:0]), .out_valid(ov[2]), .out_ready(ordy),
    .out_degree(d2), .out_zero(z[2]), .out_pow2(p[2]));

  log2_seq #(.WIDTH(64), .CHUNK(16)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_num(num), .out_valid(ov[3]), .out_ready(ordy),
    .out_degree(d3), .out_zero(z[3]), .out_pow2(p[3]));

  typedef struct {
    int          s;
    logic [63:0] x;
    int          hold;
    int          deg;
    bit          zf;
    bit          pf;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)",
               name, act, exp, sel, $time);
    end
  endtask

  task automatic run(input int s, input logic [63:0] x,
                     input int hold, input int edeg, input bit ez,
                     input bit ep, input int elat);
    int n;
    sel  = s;
    ordy = (hold == 0);
    num  = x;
    vld  = 1'b1;
    #1;
    chk("in_ready_idle", cur_ir, 1);
    @(posedge clk); #1;
    vld = 1'b0;
    chk("in_ready_busy", cur_ir, 0);
    n = 0;
    while (!cur_ov && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", cur_ov, 1);
    chk("latency", n, elat);
    chk("degree", cur_deg, edeg);
    chk("zero", cur_z, ez);
    chk("pow2", cur_p, ep);
    for (int i = 0; i < hold; i++) begin
      num = {$urandom, $urandom};
      vld = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", cur_ov, 1);
      chk("hold_degree", cur_deg, edeg);
      chk("hold_zero", cur_z, ez);
      chk("hold_pow2", cur_p, ep);
      chk("hold_in_ready", cur_ir, 0);
    end
    vld  = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    chk("post_in_ready", cur_ir, 1);
    chk("post_valid", cur_ov, 0);
    chk("post_degree", cur_deg, edeg);
  endtask

  function automatic int ref_log2(input logic [63:0] v);
    int d = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      d++;
    end
    return d;
  endfunction

  task automatic run_model(input int s, input logic [63:0] x,
                           input int hold);
    logic [63:0] xm;
    int          d, nch, lat;
    bit          zf, pf;
    xm  = x & ((64'd1 << WS[s]) - 64'd1);
    zf  = (xm == 64'd0);
    pf  = ($countones(xm) == 1);
    d   = ref_log2(xm);
    nch = WS[s] / CS[s];
    lat = zf ? nch : nch - d / CS[s];
    run(s, x, hold, d, zf, pf, lat);
  endtask

  initial begin
    int seen;
    logic [63:0] r;
    rst_n = 1'b0;
    vld   = 1'b0;
    ordy  = 1'b1;
    sel   = 0;
    num   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_all", ir, 4'hF);
    chk("rst_valid_all", ov, 4'h0);
    chk("rst_degree", cur_deg, 0);
    chk("rst_zero_all", z, 4'h0);
    chk("rst_pow2_all", p, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{0, 64'h8000_0000, 0, 31, 0, 1, 1});
    tbl.push_back('{0, 64'h0001_2345, 0, 16, 0, 0, 2});
    tbl.push_back('{0, 64'h0000_0001, 0, 0, 0, 1, 4});
    tbl.push_back('{0, 64'h0000_0000, 0, 0, 1, 0, 4});
    tbl.push_back('{0, 64'h0000_0040, 0, 6, 0, 1, 4});
    tbl.push_back('{0, 64'h0001_2345, 5, 16, 0, 0, 2});
    tbl.push_back('{0, 64'h0000_0400, 0, 10, 0, 1, 3});
    tbl.push_back('{1, 64'h80, 0, 7, 0, 1, 1});
    tbl.push_back('{2, 64'h01, 0, 0, 0, 1, 8});
    tbl.push_back('{2, 64'h00, 0, 0, 1, 0, 8});
    tbl.push_back('{3, 64'h8000_0000_0000_0000, 0, 63, 0, 1, 1});
    tbl.push_back('{3, 64'h3, 0, 1, 0, 0, 4});
    tbl.push_back('{0, 64'h0000_0040, 2, 6, 0, 1, 4});
    foreach (tbl[i])
      run(tbl[i].s, tbl[i].x, tbl[i].hold, tbl[i].deg,
          tbl[i].zf, tbl[i].pf, tbl[i].lat);

    // reset while scanning 0xFF: result must be dropped
    sel  = 0;
    num  = 64'hFF;
    vld  = 1'b1;
    ordy = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", cur_ov, 0);
    chk("arst_in_ready", cur_ir, 1);
    chk("arst_degree", cur_deg, 0);
    chk("arst_zero", cur_z, 0);
    chk("arst_pow2", cur_p, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cur_ov) seen++;
    end
    chk("no_stale_result", seen, 0);
    run(0, 64'hFF, 0, 7, 0, 0, 4);

    for (int s = 1; s <= 2; s++)
      for (int v = 0; v < 256; v++)
        run_model(s, 64'(v), 0);

    for (int i = 0; i < 200; i++) begin
      r = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_model(int'($urandom_range(0, 3)), r,
                ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(1, 3)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
